// File: rtl/pic_command_pkg.sv
// Shared definitions for the 8259A command-word front end: sequencer
// states and the bit positions used to decode written command bytes.
package pic_command_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } sequencer_state_t;

    localparam int ICW1_SELECT_BIT = 4;
    localparam int OCW3_SELECT_BIT = 3;
    localparam int SNGL_BIT        = 1;
    localparam int IC4_BIT         = 0;

    // An A0=0 write with D4 set is always ICW1, whatever state we are in.
    function automatic logic is_icw1(input logic a0, input logic [7:0] data);
        return !a0 && data[ICW1_SELECT_BIT];
    endfunction

endpackage

// File: rtl/command_word_sequencer_bus_write_detector.sv
// CPU bus write detector: latches the byte and A0 on every active edge and
// pulses write_end on the first edge that sees the write gone.
module bus_write_detector (
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       latched_address,
    output logic       write_end
);

    logic write_active;
    logic prev_active_reg;

    // Either CS_n or WR_n going high ends the write.
    assign write_active = !chip_select_n && !write_enable_n;

    // Combinational so the sequencer registers its strobe on the same edge
    // that first samples the write inactive.
    assign write_end = prev_active_reg && !write_active;

    // Track the previous active state and capture data/A0 while the write is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_active_reg   <= 1'b0;
            internal_data_bus <= 8'h00;
            latched_address   <= 1'b0;
        end else begin
            prev_active_reg <= write_active;
            if (write_active) begin
                internal_data_bus <= data_bus_in;
                latched_address   <= address;
            end
        end
    end

endmodule

// File: rtl/command_word_sequencer.sv
// 8259A bus-write front end: tracks the ICW1..ICW4 initialization sequence
// and emits one-cycle registered strobes for each completed command word.
module command_word_sequencer
    import pic_command_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1_registers,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       single_mode,
    output logic       icw4_required,
    output logic       initialization_complete
);

    sequencer_state_t state_reg;
    logic             latched_address;
    logic             write_end;

    bus_write_detector u_bus_write_detector (
        .clock             (clock),
        .reset             (reset),
        .chip_select_n     (chip_select_n),
        .write_enable_n    (write_enable_n),
        .address           (address),
        .data_bus_in       (data_bus_in),
        .internal_data_bus (internal_data_bus),
        .latched_address   (latched_address),
        .write_end         (write_end)
    );

    // Sequencer FSM: decode each completed write, update state and pulse one strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg                                <= UNINIT;
            write_initial_command_word_1             <= 1'b0;
            write_initial_command_word_2             <= 1'b0;
            write_initial_command_word_3             <= 1'b0;
            write_initial_command_word_4             <= 1'b0;
            write_operation_control_word_1_registers <= 1'b0;
            write_operation_control_word_2           <= 1'b0;
            write_operation_control_word_3           <= 1'b0;
            single_mode                              <= 1'b0;
            icw4_required                            <= 1'b0;
            initialization_complete                  <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless a write ends this edge.
            write_initial_command_word_1             <= 1'b0;
            write_initial_command_word_2             <= 1'b0;
            write_initial_command_word_3             <= 1'b0;
            write_initial_command_word_4             <= 1'b0;
            write_operation_control_word_1_registers <= 1'b0;
            write_operation_control_word_2           <= 1'b0;
            write_operation_control_word_3           <= 1'b0;

            if (write_end) begin
                if (is_icw1(latched_address, internal_data_bus)) begin
                    // ICW1 restarts initialization from any state.
                    write_initial_command_word_1 <= 1'b1;
                    single_mode                  <= internal_data_bus[SNGL_BIT];
                    icw4_required                <= internal_data_bus[IC4_BIT];
                    initialization_complete      <= 1'b0;
                    state_reg                    <= WAIT_ICW2;
                end else begin
                    case (state_reg)
                        WAIT_ICW2: begin
                            if (latched_address) begin
                                write_initial_command_word_2 <= 1'b1;
                                if (!single_mode) begin
                                    state_reg <= WAIT_ICW3;
                                end else if (icw4_required) begin
                                    state_reg <= WAIT_ICW4;
                                end else begin
                                    state_reg               <= READY;
                                    initialization_complete <= 1'b1;
                                end
                            end
                        end
                        WAIT_ICW3: begin
                            if (latched_address) begin
                                write_initial_command_word_3 <= 1'b1;
                                if (icw4_required) begin
                                    state_reg <= WAIT_ICW4;
                                end else begin
                                    state_reg               <= READY;
                                    initialization_complete <= 1'b1;
                                end
                            end
                        end
                        WAIT_ICW4: begin
                            if (latched_address) begin
                                write_initial_command_word_4 <= 1'b1;
                                state_reg                    <= READY;
                                initialization_complete      <= 1'b1;
                            end
                        end
                        READY: begin
                            if (latched_address) begin
                                write_operation_control_word_1_registers <= 1'b1;
                            end else if (internal_data_bus[OCW3_SELECT_BIT]) begin
                                write_operation_control_word_3 <= 1'b1;
                            end else begin
                                write_operation_control_word_2 <= 1'b1;
                            end
                        end
                        default: begin
                            // UNINIT: anything other than ICW1 is ignored.
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_command_word_sequencer.sv
// Self-checking bench for command_word_sequencer: expected strobes are queued
// as writes are driven and compared with strobes collected by a monitor.
module tb_command_word_sequencer;

    logic       clock;
    logic       reset;
    logic       chip_select_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_in;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2;
    logic       write_initial_command_word_3;
    logic       write_initial_command_word_4;
    logic       write_operation_control_word_1_registers;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic       single_mode;
    logic       icw4_required;
    logic       initialization_complete;

    // Strobe vector order: {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_ICW1 = 7'b1000000;
    localparam logic [6:0] S_ICW2 = 7'b0100000;
    localparam logic [6:0] S_ICW3 = 7'b0010000;
    localparam logic [6:0] S_ICW4 = 7'b0001000;
    localparam logic [6:0] S_OCW1 = 7'b0000100;
    localparam logic [6:0] S_OCW2 = 7'b0000010;
    localparam logic [6:0] S_OCW3 = 7'b0000001;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_q[$];   // {strobe vector, data byte}
    logic [14:0] obs_q[$];
    int          multi_hot_count = 0;

    logic [6:0] strobes;
    assign strobes = {write_initial_command_word_1, write_initial_command_word_2,
                      write_initial_command_word_3, write_initial_command_word_4,
                      write_operation_control_word_1_registers,
                      write_operation_control_word_2, write_operation_control_word_3};

    command_word_sequencer dut (
        .clock                                    (clock),
        .reset                                    (reset),
        .chip_select_n                            (chip_select_n),
        .write_enable_n                           (write_enable_n),
        .address                                  (address),
        .data_bus_in                              (data_bus_in),
        .internal_data_bus                        (internal_data_bus),
        .write_initial_command_word_1             (write_initial_command_word_1),
        .write_initial_command_word_2             (write_initial_command_word_2),
        .write_initial_command_word_3             (write_initial_command_word_3),
        .write_initial_command_word_4             (write_initial_command_word_4),
        .write_operation_control_word_1_registers (write_operation_control_word_1_registers),
        .write_operation_control_word_2           (write_operation_control_word_2),
        .write_operation_control_word_3           (write_operation_control_word_3),
        .single_mode                              (single_mode),
        .icw4_required                            (icw4_required),
        .initialization_complete                  (initialization_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every cycle with any strobe high becomes one observed entry.
    always @(negedge clock) begin
        if (!reset && strobes != S_NONE) begin
            obs_q.push_back({strobes, internal_data_bus});
            if ($countones(strobes) > 1) multi_hot_count++;
        end
    end

    // Drive one write, held active for 'hold' rising edges; cs_only ends it
    // by raising CS_n while WR_n stays low.
    task automatic drive_write(input logic a0, input logic [7:0] d, input int hold,
                               input logic [6:0] exp_strobe, input bit cs_only);
        @(negedge clock);
        chip_select_n  = 1'b0;
        write_enable_n = 1'b0;
        address        = a0;
        data_bus_in    = d;
        if (exp_strobe != S_NONE) exp_q.push_back({exp_strobe, d});
        repeat (hold) @(negedge clock);
        chip_select_n = 1'b1;
        if (!cs_only) write_enable_n = 1'b1;
        data_bus_in = 8'hXX;
    endtask

    task automatic check_scoreboard(input string name);
        logic [14:0] e;
        logic [14:0] o;
        repeat (4) @(negedge clock);
        write_enable_n = 1'b1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s strobe_count actual=%0d required=%0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s strobe actual=%b/%h required=%b/%h", name,
                         o[14:8], o[7:0], e[14:8], e[7:0]);
            end else begin
                $display("%s: strobe %b data %h", name, o[14:8], o[7:0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string name, input logic sm, input logic ic4, input logic done);
        checks++;
        if ({single_mode, icw4_required, initialization_complete} !== {sm, ic4, done}) begin
            failures++;
            $display("FAIL %s flags sngl/ic4/done actual=%b%b%b required=%b%b%b", name,
                     single_mode, icw4_required, initialization_complete, sm, ic4, done);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({internal_data_bus, strobes, single_mode, icw4_required, initialization_complete} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h/%b/%b%b%b required=00/0000000/000",
                     internal_data_bus, strobes, single_mode, icw4_required, initialization_complete);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_flags("reset_release", 1'b0, 1'b0, 1'b0);
        $display("reset: outputs cleared");
    endtask

    task automatic test_uninit_drop;
        drive_write(1'b1, 8'hFF, 2, S_NONE, 1'b0);
        check_scoreboard("uninit_drop");
        checks++;
        if (internal_data_bus !== 8'hFF) begin
            failures++;
            $display("FAIL uninit_data actual=%h required=ff", internal_data_bus);
        end
        check_flags("uninit_state", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_sequence;
        drive_write(1'b0, 8'h11, 1, S_ICW1, 1'b0);
        drive_write(1'b1, 8'h20, 1, S_ICW2, 1'b0);
        drive_write(1'b1, 8'h04, 2, S_ICW3, 1'b0);
        check_scoreboard("full_seq_icw123");
        check_flags("full_seq_mid", 1'b0, 1'b1, 1'b0);
        drive_write(1'b1, 8'h01, 1, S_ICW4, 1'b0);
        // Cycle after the ICW4 strobe: READY must be reported.
        @(negedge clock);
        @(negedge clock);
        check_flags("full_seq_ready", 1'b0, 1'b1, 1'b1);
        check_scoreboard("full_seq_icw4");
    endtask

    task automatic test_ready_ocw;
        drive_write(1'b1, 8'h0F, 1, S_OCW1, 1'b0);
        drive_write(1'b0, 8'h20, 1, S_OCW2, 1'b0);
        drive_write(1'b0, 8'h0B, 1, S_OCW3, 1'b0);
        drive_write(1'b1, 8'h3C, 7, S_OCW1, 1'b0);   // long write, single strobe
        check_scoreboard("ready_ocw");
        check_flags("ready_ocw_state", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_single_mode;
        drive_write(1'b0, 8'h12, 1, S_ICW1, 1'b0);
        check_scoreboard("single_icw1");
        check_flags("single_after_icw1", 1'b1, 1'b0, 1'b0);
        drive_write(1'b1, 8'h08, 1, S_ICW2, 1'b0);
        check_scoreboard("single_icw2");
        check_flags("single_ready", 1'b1, 1'b0, 1'b1);
        drive_write(1'b1, 8'h77, 1, S_OCW1, 1'b0);   // READY, not ICW3
        check_scoreboard("single_then_ocw1");
    endtask

    task automatic test_abort;
        drive_write(1'b0, 8'h11, 1, S_ICW1, 1'b0);
        drive_write(1'b1, 8'h20, 1, S_ICW2, 1'b0);   // now WAIT_ICW3
        drive_write(1'b0, 8'h13, 1, S_ICW1, 1'b0);   // restart
        check_scoreboard("abort_icw1");
        check_flags("abort_flags", 1'b1, 1'b1, 1'b0);
        drive_write(1'b0, 8'h00, 1, S_NONE, 1'b0);   // dropped while waiting
        drive_write(1'b1, 8'h40, 1, S_ICW2, 1'b0);   // WAIT_ICW2 -> WAIT_ICW4
        drive_write(1'b1, 8'h03, 1, S_ICW4, 1'b0);
        check_scoreboard("abort_resume");
        check_flags("abort_ready", 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        drive_write(1'b1, 8'h55, 1, S_OCW1, 1'b0);
        drive_write(1'b1, 8'hAA, 1, S_OCW1, 1'b0);
        drive_write(1'b0, 8'h08, 1, S_OCW3, 1'b0);
        drive_write(1'b0, 8'h07, 2, S_OCW2, 1'b1);   // ended by CS_n alone
        check_scoreboard("back_to_back");
    endtask

    task automatic test_reset_mid_write;
        @(negedge clock);
        chip_select_n  = 1'b0;
        write_enable_n = 1'b0;
        address        = 1'b1;
        data_bus_in    = 8'h99;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({internal_data_bus, strobes, single_mode, icw4_required, initialization_complete} !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_write_outputs actual=%h/%b/%b%b%b required=00/0000000/000",
                     internal_data_bus, strobes, single_mode, icw4_required, initialization_complete);
        end
        @(negedge clock);
        chip_select_n  = 1'b1;
        write_enable_n = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_scoreboard("reset_mid_write");
        check_flags("reset_mid_write_state", 1'b0, 1'b0, 1'b0);
        drive_write(1'b1, 8'h5A, 1, S_NONE, 1'b0);   // UNINIT drops it
        check_scoreboard("after_reset_uninit");
    endtask

    task automatic test_one_hot;
        checks++;
        if (multi_hot_count != 0) begin
            failures++;
            $display("FAIL one_hot multi_strobe_cycles actual=%0d required=0", multi_hot_count);
        end
    endtask

    initial begin
        reset          = 1'b1;
        chip_select_n  = 1'b1;
        write_enable_n = 1'b1;
        address        = 1'b0;
        data_bus_in    = 8'h00;
        test_reset();
        test_uninit_drop();
        test_full_sequence();
        test_ready_ocw();
        test_single_mode();
        test_abort();
        test_back_to_back();
        test_reset_mid_write();
        test_one_hot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
